// File: rtl/ahbl_apb3_multi_bridge_if.sv
// ahbl_apb3_multi_bridge_if: AHB-Lite slave side and APB3 master side signals of the bridge
interface ahbl_apb3_multi_bridge_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32
);
  logic                    HSEL;
  logic [ADDR_WIDTH-1:0]   HADDR;
  logic [1:0]              HTRANS;
  logic                    HWRITE;
  logic [31:0]             HWDATA;
  logic                    HREADY;
  logic [31:0]             HRDATA;
  logic                    HREADYOUT;
  logic [1:0]              HRESP;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [NUM_SLAVES-1:0]   PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [31:0]             PWDATA;
  logic [32*NUM_SLAVES-1:0] PRDATA;
  logic [NUM_SLAVES-1:0]   PREADY;
  logic [NUM_SLAVES-1:0]   PSLVERR;
  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
    output HRDATA, HREADYOUT, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY, PRDATA, PREADY, PSLVERR,
    input  HRDATA, HREADYOUT, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA
  );
endinterface

// File: rtl/ahbl_apb3_multi_bridge.sv
// ahbl_apb3_multi_bridge: AHB-Lite slave to multi-slot APB3 master bridge with fully registered outputs
module ahbl_apb3_multi_bridge #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int SLOT_SHIFT = 12,
  parameter int TIMEOUT    = 0
) (
  input logic HCLK,
  input logic HRESETN,
  ahbl_apb3_multi_bridge_if.slave bus
);
  typedef enum logic [2:0] {IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2} state_t;
  state_t state, nxt;
  logic [3:0] slot_q, slot_in;
  logic valid, mapped, capture, sel_ready, sel_err, tout;
  logic [31:0] tcnt, sel_rdata;
  logic [NUM_SLAVES-1:0] onehot;
  assign valid = bus.HSEL & bus.HREADY & (bus.HTRANS inside {2'b10, 2'b11});
  assign slot_in = bus.HADDR[SLOT_SHIFT+3:SLOT_SHIFT];
  assign mapped = int'(slot_in) < NUM_SLAVES;
  assign capture = valid & (state == IDLE || state == ERR2);
  assign onehot = NUM_SLAVES'(1) << slot_q;
  assign sel_ready = |(bus.PREADY & bus.PSEL);
  assign sel_err = |(bus.PSLVERR & bus.PSEL);
  assign tout = (TIMEOUT > 0) && (tcnt == 32'(TIMEOUT - 1)) && !sel_ready;
  // PSEL is one-hot during an APB access, so masking by it selects the addressed slot's read data
  always_comb begin
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) sel_rdata = sel_rdata | (bus.PSEL[k] ? bus.PRDATA[32*k +: 32] : 32'd0);
  end
  // Next-state logic; IDLE and ERR2 are the HREADYOUT=1 cycles that may accept a new transfer
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, ERR2: nxt = valid ? (mapped ? WDATA : ERR1) : IDLE;
      WDATA:      nxt = SETUP;
      SETUP:      nxt = ACCESS;
      ACCESS:     nxt = sel_ready ? (sel_err ? ERR1 : IDLE) : (tout ? ERR1 : ACCESS);
      ERR1:       nxt = ERR2;
      default:    nxt = IDLE;
    endcase
  end
  // State, captured request, data paths and every bus output are registered from the next state
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      state         <= IDLE;
      tcnt          <= '0;
      slot_q        <= '0;
      bus.HRDATA    <= '0;
      bus.HREADYOUT <= 1'b1;
      bus.HRESP     <= 2'b00;
      bus.PADDR     <= '0;
      bus.PSEL      <= '0;
      bus.PENABLE   <= 1'b0;
      bus.PWRITE    <= 1'b0;
      bus.PWDATA    <= '0;
    end else begin
      state <= nxt;
      tcnt  <= (state == ACCESS && !sel_ready) ? tcnt + 32'd1 : '0;
      if (capture) begin
        slot_q     <= slot_in;
        bus.PADDR  <= bus.HADDR;
        bus.PWRITE <= bus.HWRITE;
      end
      if (state == WDATA && bus.PWRITE) bus.PWDATA <= bus.HWDATA;
      if (state == ACCESS && sel_ready && !bus.PWRITE) bus.HRDATA <= sel_rdata;
      bus.PSEL      <= (nxt == SETUP || nxt == ACCESS) ? onehot : '0;
      bus.PENABLE   <= nxt == ACCESS;
      bus.HREADYOUT <= nxt inside {IDLE, ERR2};
      bus.HRESP     <= (nxt inside {ERR1, ERR2}) ? 2'b01 : 2'b00;
    end
  end
endmodule

// File: tb/tb_ahbl_apb3_multi_bridge.sv
// tb_ahbl_apb3_multi_bridge: transaction-level timeline model plus directed vectors for the bridge
module tb_ahbl_apb3_multi_bridge;
  localparam int TO = 8;
  typedef struct packed {
    int          cyc;
    logic        ro;
    logic [1:0]  rs;
    logic [3:0]  ps;
    logic        pe;
    logic        ck;
    logic [31:0] paddr;
    logic        pwr;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
  } exp_t;
  logic HCLK = 1'b0;
  logic HRESETN = 1'b1;
  int cyc = 0, n_cmp = 0, n_err = 0, acc_cnt = 0;
  bit run = 1'b0;
  int wait_n [4];
  bit err_n [4];
  logic [31:0] prdata_v [4];
  exp_t q [$];
  logic [31:0] plan_paddr = '0, plan_pwdata = '0, plan_hrdata = '0, model_hrdata = '0;
  logic plan_pwrite = 1'b0;
  logic [31:0] lg_ro [512], lg_resp [512], lg_psel [512], lg_paddr [512], lg_pwdata [512], lg_hrdata [512];
  ahbl_apb3_multi_bridge_if #(.NUM_SLAVES(4), .ADDR_WIDTH(32)) bus ();
  ahbl_apb3_multi_bridge #(.NUM_SLAVES(4), .ADDR_WIDTH(32), .SLOT_SHIFT(12), .TIMEOUT(TO)) dut (
    .HCLK(HCLK), .HRESETN(HRESETN), .bus(bus)
  );
  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;
  always @(posedge HCLK) acc_cnt <= bus.PENABLE ? acc_cnt + 1 : 0;
  // APB slaves: the selected slot becomes ready after wait_n ACCESS cycles; unselected slots show noise
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      bus.PRDATA[32*k +: 32] = prdata_v[k];
      bus.PREADY[k]  = (bus.PSEL[k] && bus.PENABLE) ? (acc_cnt >= wait_n[k]) : 1'b1;
      bus.PSLVERR[k] = (bus.PSEL[k] && bus.PENABLE) ? ((acc_cnt >= wait_n[k]) && err_n[k]) : 1'b1;
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask
  function automatic void push(input int c, input logic ro, input logic [1:0] rs, input logic [3:0] ps,
                               input logic pe, input logic ck);
    exp_t e;
    e.cyc = c; e.ro = ro; e.rs = rs; e.ps = ps; e.pe = pe; e.ck = ck;
    e.paddr = plan_paddr; e.pwr = plan_pwrite; e.pwdata = plan_pwdata; e.hrdata = plan_hrdata;
    q.push_back(e);
  endfunction
  // Timeline of a transfer whose address phase is cycle n; returns the cycle that may take the next one
  function automatic int plan(input logic [31:0] a, input logic wr, input logic [31:0] wd, input int n);
    int s, acc, e_c;
    logic [3:0] oh;
    bit to;
    s = int'(a[15:12]);
    if (s >= 4) begin
      push(n + 1, 1'b0, 2'b01, 4'b0, 1'b0, 1'b0);
      push(n + 2, 1'b1, 2'b01, 4'b0, 1'b0, 1'b0);
      return n + 2;
    end
    oh = 4'b0001 << s;
    plan_paddr = a;
    plan_pwrite = wr;
    push(n + 1, 1'b0, 2'b00, 4'b0, 1'b0, 1'b0);
    if (wr) plan_pwdata = wd;
    push(n + 2, 1'b0, 2'b00, oh, 1'b0, 1'b1);
    to = wait_n[s] >= TO;
    acc = to ? TO : wait_n[s] + 1;
    for (int j = 0; j < acc; j++) push(n + 3 + j, 1'b0, 2'b00, oh, 1'b1, 1'b1);
    e_c = n + 3 + acc;
    if (!to && !wr) plan_hrdata = prdata_v[s];
    if (!to && !err_n[s]) begin
      push(e_c, 1'b1, 2'b00, 4'b0, 1'b0, 1'b0);
      return e_c;
    end
    push(e_c, 1'b0, 2'b01, 4'b0, 1'b0, 1'b0);
    push(e_c + 1, 1'b1, 2'b01, 4'b0, 1'b0, 1'b0);
    return e_c + 1;
  endfunction
  // Compare process: every cycle out of reset, the DUT must match the model's entry or the idle default
  always @(negedge HCLK) begin
    exp_t e;
    if (run && HRESETN) begin
      e = '0;
      e.cyc = cyc; e.ro = 1'b1; e.hrdata = model_hrdata;
      if (q.size() != 0 && q[0].cyc == cyc) e = q.pop_front();
      model_hrdata = e.hrdata;
      chk("HREADYOUT", 32'(bus.HREADYOUT), 32'(e.ro));
      chk("HRESP", 32'(bus.HRESP), 32'(e.rs));
      chk("PSEL", 32'(bus.PSEL), 32'(e.ps));
      chk("PENABLE", 32'(bus.PENABLE), 32'(e.pe));
      chk("HRDATA", bus.HRDATA, e.hrdata);
      if (e.ck) begin
        chk("PADDR", bus.PADDR, e.paddr);
        chk("PWRITE", 32'(bus.PWRITE), 32'(e.pwr));
        chk("PWDATA", bus.PWDATA, e.pwdata);
      end
      if (cyc < 512) begin
        lg_ro[cyc] = 32'(bus.HREADYOUT); lg_resp[cyc] = 32'(bus.HRESP); lg_psel[cyc] = 32'(bus.PSEL);
        lg_paddr[cyc] = bus.PADDR; lg_pwdata[cyc] = bus.PWDATA; lg_hrdata[cyc] = bus.HRDATA;
      end
    end
  end
  task automatic step();
    @(posedge HCLK);
    #1;
  endtask
  task automatic issue(input logic [31:0] a, input logic wr, input logic [31:0] wd, output int n);
    int f;
    n = cyc;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = a; bus.HWRITE = wr;
    f = plan(a, wr, wd, n);
    step();
    bus.HWDATA = wd; bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    for (int i = 0; i < 64 && cyc < f; i++) step();
  endtask
  task automatic chk_reset_values(input string tag);
    chk({tag, "_HREADYOUT"}, 32'(bus.HREADYOUT), 32'd1);
    chk({tag, "_HRESP"}, 32'(bus.HRESP), 32'd0);
    chk({tag, "_HRDATA"}, bus.HRDATA, 32'd0);
    chk({tag, "_PSEL"}, 32'(bus.PSEL), 32'd0);
    chk({tag, "_PENABLE"}, 32'(bus.PENABLE), 32'd0);
    chk({tag, "_PWRITE"}, 32'(bus.PWRITE), 32'd0);
    chk({tag, "_PADDR"}, bus.PADDR, 32'd0);
    chk({tag, "_PWDATA"}, bus.PWDATA, 32'd0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n1, n2, n3, n4, n5, n6, n7, n8, n9;
    for (int k = 0; k < 4; k++) begin
      wait_n[k] = 0; err_n[k] = 1'b0; prdata_v[k] = 32'h1111_0000 * (k + 1);
    end
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1;
    #2 HRESETN = 1'b0;
    #1 chk_reset_values("por");
    step(); step(); step();
    HRESETN = 1'b1;
    run = 1'b1;
    step(); step();
    bus.HSEL = 1'b1; bus.HADDR = 32'h0000_1000; bus.HTRANS = 2'b01;
    step();
    bus.HTRANS = 2'b00;
    step();
    bus.HTRANS = 2'b10; bus.HREADY = 1'b0;
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HREADY = 1'b1;
    step();
    issue(32'h0000_1010, 1'b1, 32'hA5A5_0001, n1);
    step();
    chk("w1_psel", lg_psel[n1 + 2], 32'h2);
    chk("w1_paddr", lg_paddr[n1 + 2], 32'h1010);
    chk("w1_pwdata", lg_pwdata[n1 + 2], 32'hA5A5_0001);
    chk("w1_wait", lg_ro[n1 + 3], 32'd0);
    chk("w1_done", lg_ro[n1 + 4], 32'd1);
    chk("w1_okay", lg_resp[n1 + 4], 32'd0);
    wait_n[3] = 3; prdata_v[3] = 32'hDEAD_BEEF;
    issue(32'h0000_3004, 1'b0, 32'h0, n2);
    step();
    chk("r3_wait", lg_ro[n2 + 6], 32'd0);
    chk("r3_done", lg_ro[n2 + 7], 32'd1);
    chk("r3_okay", lg_resp[n2 + 7], 32'd0);
    chk("r3_data", lg_hrdata[n2 + 7], 32'hDEAD_BEEF);
    wait_n[3] = 0;
    err_n[0] = 1'b1;
    issue(32'h0000_7000, 1'b1, 32'h55, n3);
    issue(32'h0000_0008, 1'b1, 32'h0BAD_0008, n4);
    step();
    chk("um_psel1", lg_psel[n3 + 1], 32'd0);
    chk("um_psel2", lg_psel[n3 + 2], 32'd0);
    chk("um_ro1", lg_ro[n3 + 1], 32'd0);
    chk("um_resp1", lg_resp[n3 + 1], 32'd1);
    chk("um_ro2", lg_ro[n3 + 2], 32'd1);
    chk("um_resp2", lg_resp[n3 + 2], 32'd1);
    chk("se_b2b", 32'(n4), 32'(n3 + 2));
    chk("se_psel", lg_psel[n4 + 3], 32'h1);
    chk("se_ro1", lg_ro[n4 + 4], 32'd0);
    chk("se_resp1", lg_resp[n4 + 4], 32'd1);
    chk("se_ro2", lg_ro[n4 + 5], 32'd1);
    chk("se_resp2", lg_resp[n4 + 5], 32'd1);
    err_n[0] = 1'b0;
    wait_n[2] = 255;
    issue(32'h0000_2000, 1'b0, 32'h0, n5);
    step();
    chk("to_psel_last", lg_psel[n5 + 10], 32'h4);
    chk("to_psel_drop", lg_psel[n5 + 11], 32'd0);
    chk("to_resp", lg_resp[n5 + 11], 32'd1);
    chk("to_ro", lg_ro[n5 + 12], 32'd1);
    chk("to_hrdata", lg_hrdata[n5 + 12], 32'hDEAD_BEEF);
    wait_n[2] = 0; prdata_v[2] = 32'h2222_C0DE;
    issue(32'h0000_0100, 1'b1, 32'h0BAD_F00D, n6);
    issue(32'h0000_2040, 1'b0, 32'h0, n7);
    step();
    chk("bb_w_psel", lg_psel[n6 + 2], 32'h1);
    chk("bb_w_pwdata", lg_pwdata[n6 + 2], 32'h0BAD_F00D);
    chk("bb_gap", 32'(n7), 32'(n6 + 4));
    chk("bb_r_psel", lg_psel[n7 + 2], 32'h4);
    chk("bb_r_paddr", lg_paddr[n7 + 2], 32'h2040);
    chk("bb_r_data", lg_hrdata[n7 + 4], 32'h2222_C0DE);
    wait_n[1] = 255;
    n8 = cyc;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h0000_1000; bus.HWRITE = 1'b0;
    void'(plan(32'h0000_1000, 1'b0, 32'h0, n8));
    step();
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    step(); step(); step();
    chk("rst_in_access", 32'(bus.PENABLE), 32'd1);
    #2 HRESETN = 1'b0;
    #1 chk_reset_values("mid");
    q.delete();
    plan_hrdata = '0; plan_pwdata = '0; model_hrdata = '0;
    step(); step();
    HRESETN = 1'b1;
    for (int i = 0; i < 5; i++) step();
    wait_n[1] = 0; wait_n[3] = 1;
    issue(32'h0000_3FFC, 1'b1, 32'h1234_5678, n9);
    step();
    chk("rec_psel", lg_psel[n9 + 2], 32'h8);
    chk("rec_done", lg_ro[n9 + 5], 32'd1);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
